// File: rtl/lc3b_types.sv
// Shared LC-3b bus types plus the line responder state encoding.
// Imported by pmem_line_responder and pmem_line_array.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_data;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } pmem_resp_state_t;

   localparam int LINE_OFS_BITS = 4;

endpackage

// File: rtl/pmem_line_array.sv
// Line-addressed 128-bit store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module pmem_line_array
   import lc3b_types::*;
#(
   parameter int DEPTH_LINES = 256,
   localparam int IW = $clog2(DEPTH_LINES)
) (
   input  logic          clk,
   input  logic          write,
   input  logic [IW-1:0] index,
   input  lc3b_data      datain,
   output lc3b_data      dataout
);

   lc3b_data r_mem [DEPTH_LINES];

   // commit one line on the write strobe
   always_ff @(posedge clk) begin
      if (write) begin
         r_mem[index] <= datain;
      end
   end

   assign dataout = r_mem[index];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical memory line responder for the write-back buffer.
// Optional PMEM_LINE_STAT_EN adds completed read/write counters.
module pmem_line_responder
   import lc3b_types::*;
#(
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  lc3b_word    pmem_address,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  lc3b_data    pmem_wdata,
   output lc3b_data    pmem_rdata,
   output logic        pmem_resp
`ifdef PMEM_LINE_STAT_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   localparam int IW = $clog2(DEPTH_LINES);
   localparam int CW = $clog2(LATENCY + 1);

   pmem_resp_state_t r_state;
   pmem_resp_state_t w_state_nxt;
   logic [CW-1:0]    r_lat_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [IW-1:0]    r_index;
   lc3b_data         r_wdata;
   logic             r_op_wr;
   lc3b_data         r_rdata;
   lc3b_data         w_dout;
   logic             w_accept;
   logic             w_resp;
   logic             w_arr_wr;
   logic             w_rd_done;
   logic             w_unused_addr;

   // low offset and high alias bits of the address carry no meaning here
   assign w_unused_addr = ^pmem_address;

   // state and latency counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_lat_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lat_cnt <= w_cnt_nxt;
      end
   end

   // next-state, latency countdown and response decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_lat_cnt;
      w_accept    = 1'b0;
      w_resp      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (pmem_read | pmem_write) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = CW'(LATENCY - 1);
               w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            w_cnt_nxt = r_lat_cnt - CW'(1);
            if (r_lat_cnt == CW'(1)) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_resp      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // capture the request at accept; later input changes are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_index <= '0;
         r_wdata <= '0;
         r_op_wr <= 1'b0;
      end else if (w_accept) begin
         r_index <= pmem_address[LINE_OFS_BITS +: IW];
         r_wdata <= pmem_wdata;
         r_op_wr <= pmem_write;
      end
   end

   assign w_arr_wr  = w_resp & r_op_wr;
   assign w_rd_done = w_resp & ~r_op_wr;

   pmem_line_array #(
      .DEPTH_LINES (DEPTH_LINES)
   ) u_array (
      .clk     (clk),
      .write   (w_arr_wr),
      .index   (r_index),
      .datain  (r_wdata),
      .dataout (w_dout)
   );

   // hold the last returned line so writes leave the read bus untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (w_rd_done) begin
         r_rdata <= w_dout;
      end
   end

   assign pmem_rdata = w_rd_done ? w_dout : r_rdata;
   assign pmem_resp  = w_resp;

`ifdef PMEM_LINE_STAT_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   // count completed ops on their response edge, wrapping at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_rd_done) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
         if (w_arr_wr) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder (DEPTH_LINES=256, LATENCY=4).
// Stat counter checks apply when PMEM_LINE_STAT_EN is defined.
module tb_pmem_line_responder;

   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         clk;
   logic         reset;
`ifdef PMEM_LINE_STAT_EN
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;
`endif

   int n_vec;
   int n_err;
   logic [127:0] last_rd;

   localparam logic [127:0] DA5 = {16{8'hA5}};
   localparam logic [127:0] D0  = 128'h0D0D_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] D1  = 128'hD1D1_0123_4567_89AB_CDEF_FEDC_BA98_7654;
   localparam logic [127:0] D2  = 128'hD2D2_2222_0000_FFFF_1234_5678_9ABC_DEF0;
   localparam logic [127:0] D3  = 128'hD3D3_3333_CAFE_BABE_DEAD_BEEF_0BAD_F00D;
   localparam logic [127:0] D4  = 128'hD4D4_4444_4444_4444_4444_4444_4444_4444;
   localparam logic [127:0] D5  = 128'hD5D5_5555_AAAA_5555_AAAA_5555_AAAA_5555;
   localparam logic [127:0] D6  = 128'hD6D6_6666_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0;

   pmem_line_responder #(
      .DEPTH_LINES (256),
      .LATENCY     (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
`ifdef PMEM_LINE_STAT_EN
      ,
      .rd_count     (rd_count),
      .wr_count     (wr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // present a request at a negedge, check resp only at accept+4,
   // then check rdata in the resp cycle and drop the request
   task automatic op(input string tag, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [127:0] d,
                     input logic [127:0] exp_rd);
      @(negedge clk);
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = a;
      pmem_wdata   = d;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 2) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
         chk({tag, "_resp"}, {127'd0, pmem_resp}, {127'd0, k == 4});
      end
      chk({tag, "_rdata"}, pmem_rdata, exp_rd);
      if (!wr) last_rd = exp_rd;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      last_rd      = '0;
      pmem_address = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_wdata   = '0;
      reset        = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_resp", {127'd0, pmem_resp}, 128'd0);
      chk("rst_rdata", pmem_rdata, 128'd0);
`ifdef PMEM_LINE_STAT_EN
      chk("rst_rdcnt", {112'd0, rd_count}, 128'd0);
      chk("rst_wrcnt", {112'd0, wr_count}, 128'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      op("wr40", 1'b0, 1'b1, 16'h0040, DA5, 128'd0);
      op("rd4f", 1'b1, 1'b0, 16'h004F, '0, DA5);

      op("wr10", 1'b0, 1'b1, 16'h0010, D1, DA5);
      op("rd1010", 1'b1, 1'b0, 16'h1010, '0, D1);

      op("wr20", 1'b0, 1'b1, 16'h0020, D2, D1);
      op("b2b_rd20", 1'b1, 1'b0, 16'h0020, '0, D2);

      op("both30", 1'b1, 1'b1, 16'h0030, D3, D2);
      op("rd30", 1'b1, 1'b0, 16'h0030, '0, D3);

      op("wr50", 1'b0, 1'b1, 16'h0050, D0, D3);
`ifdef PMEM_LINE_STAT_EN
      @(negedge clk);
      chk("rdcnt4", {112'd0, rd_count}, 128'd4);
      chk("wrcnt5", {112'd0, wr_count}, 128'd5);
`endif

      @(negedge clk);
      pmem_write   = 1'b1;
      pmem_address = 16'h0050;
      pmem_wdata   = D4;
      repeat (2) @(negedge clk);
      pmem_write = 1'b0;
      reset      = 1'b1;
      #1;
      chk("mid_rst_resp", {127'd0, pmem_resp}, 128'd0);
      @(negedge clk);
      chk("mid_rst_rdata", pmem_rdata, 128'd0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_noresp", {127'd0, pmem_resp}, 128'd0);
      end
`ifdef PMEM_LINE_STAT_EN
      chk("abort_rdcnt", {112'd0, rd_count}, 128'd0);
      chk("abort_wrcnt", {112'd0, wr_count}, 128'd0);
`endif

      op("rd50", 1'b1, 1'b0, 16'h0050, '0, D0);
      op("wr60", 1'b0, 1'b1, 16'h0060, D5, D0);
      op("rd60", 1'b1, 1'b0, 16'h0060, '0, D5);
      op("wr70", 1'b0, 1'b1, 16'h0070, D6, D5);
      op("rd70", 1'b1, 1'b0, 16'h0070, '0, D6);
      op("rd40", 1'b1, 1'b0, 16'h0040, '0, DA5);
      @(negedge clk);
      chk("idle_hold", pmem_rdata, last_rd);
`ifdef PMEM_LINE_STAT_EN
      chk("rdcnt4b", {112'd0, rd_count}, 128'd4);
      chk("wrcnt2", {112'd0, wr_count}, 128'd2);
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_rdcnt", {112'd0, rd_count}, 128'd0);
      chk("rst2_wrcnt", {112'd0, wr_count}, 128'd0);
      reset = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
